// File: rtl/ddr2_dq_sequencer.sv
// DDR2 DQ-path sequencer: accepts write/read burst requests, times the
// write preamble/data/postamble and read capture window relative to the
// configured write/read latencies, and drives the pad enables and strobes.
module ddr2_dq_sequencer #(
    parameter int WL = 3,
    parameter int RL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        bl8,
    output logic        wr_ack,
    output logic        rd_ack,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_mask,
    output logic        wr_pop,
    output logic        ts_o,
    output logic        ri_o,
    output logic [15:0] dq_o,
    output logic [1:0]  dm_o,
    output logic [1:0]  dqs_o,
    output logic [1:0]  dqsbar_o,
    input  logic [15:0] dq_in,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_PRE,
        WR_DATA,
        WR_POST,
        RD_WAIT,
        RD_DATA,
        TURN
    } state_t;

    // Final latency-counter value in each wait state. WR_WAIT lasts WL-2
    // cycles (skipped entirely when WL=2); RD_WAIT lasts RL-1 cycles and its
    // last cycle opens the receiver one cycle ahead of the first read beat.
    localparam logic [2:0] WR_WAIT_LAST = 3'(WL - 3);
    localparam logic [2:0] RD_WAIT_LAST = 3'(RL - 2);

    state_t      state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [2:0]  beat_q, beat_d;
    logic        bl8_q, bl8_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [2:0]  last_beat;

    assign last_beat = bl8_q ? 3'd7 : 3'd3;
    assign busy      = (state_q != IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    // Next-state, counter and pad-side output decode
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        beat_d     = beat_q;
        bl8_d      = bl8_q;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        wr_pop     = 1'b0;
        ts_o       = 1'b0;
        ri_o       = 1'b0;
        dq_o       = 16'h0000;
        dm_o       = 2'b00;
        dqs_o      = 2'b00;
        dqsbar_o   = 2'b11;
        rd_valid_d = (state_q == RD_DATA);
        rd_data_d  = (state_q == RD_DATA) ? dq_in : rd_data_q;

        case (state_q)
            IDLE: begin
                // Reads win arbitration; a simultaneous write stays pending
                if (rd_req) begin
                    rd_ack  = 1'b1;
                    bl8_d   = bl8;
                    lat_d   = 3'd0;
                    state_d = RD_WAIT;
                end else if (wr_req) begin
                    wr_ack  = 1'b1;
                    bl8_d   = bl8;
                    lat_d   = 3'd0;
                    state_d = (WL == 2) ? WR_PRE : WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (lat_q == WR_WAIT_LAST) begin
                    lat_d   = 3'd0;
                    state_d = WR_PRE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            WR_PRE: begin
                ts_o    = 1'b1;
                beat_d  = 3'd0;
                state_d = WR_DATA;
            end
            WR_DATA: begin
                ts_o     = 1'b1;
                wr_pop   = 1'b1;
                dq_o     = wr_data;
                dm_o     = wr_mask;
                dqs_o    = beat_q[0] ? 2'b00 : 2'b11;
                dqsbar_o = beat_q[0] ? 2'b11 : 2'b00;
                if (beat_q == last_beat) begin
                    beat_d  = 3'd0;
                    state_d = WR_POST;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            WR_POST: begin
                ts_o    = 1'b1;
                state_d = TURN;
            end
            RD_WAIT: begin
                if (lat_q == RD_WAIT_LAST) begin
                    ri_o    = 1'b1;
                    lat_d   = 3'd0;
                    beat_d  = 3'd0;
                    state_d = RD_DATA;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RD_DATA: begin
                ri_o = 1'b1;
                if (beat_q == last_beat) begin
                    beat_d  = 3'd0;
                    state_d = TURN;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset takes priority over any pending request
        if (reset) begin
            wr_ack = 1'b0;
            rd_ack = 1'b0;
        end
    end

    // State, counters and read-capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= 3'd0;
            beat_q     <= 3'd0;
            bl8_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            beat_q     <= beat_d;
            bl8_q      <= bl8_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ddr2_dq_sequencer.sv
// Bench for ddr2_dq_sequencer: a transaction-level timing model predicts
// every output cycle by cycle from ack times and burst lengths.
module tb_ddr2_dq_sequencer;

    localparam int WL = 3;
    localparam int RL = 4;

    logic        clk = 1'b0;
    logic        reset, wr_req, rd_req, bl8;
    logic        wr_ack, rd_ack, wr_pop, ts_o, ri_o, rd_valid, busy;
    logic [15:0] wr_data, dq_o, dq_in, rd_data;
    logic [1:0]  wr_mask, dm_o, dqs_o, dqsbar_o;

    ddr2_dq_sequencer #(.WL(WL), .RL(RL)) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req), .bl8(bl8),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_pop(wr_pop), .ts_o(ts_o), .ri_o(ri_o), .dq_o(dq_o), .dm_o(dm_o),
        .dqs_o(dqs_o), .dqsbar_o(dqsbar_o), .dq_in(dq_in), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rd;
        int t;
        int bl;
        int cut;
    } txn_t;

    txn_t        txq[$];
    logic [15:0] dq_hist[int];
    int  cyc = 0;
    int  free_c = 0;
    int  last_ack = 0;
    int  compared = 0;
    int  failed = 0;
    bit  wr_want = 0, rd_want = 0, b8_cur = 0, rst_cur = 1;
    bit  directed = 0, hold_wr = 0, prev_rst = 0;
    logic [44:0] obs, exp_v;

    // Model one cycle: decide acks, drive inputs, predict and sample outputs
    task automatic run_cycle(output logic [44:0] o, output logic [44:0] e);
        bit ew = 0, er = 0, ets = 0, eri = 0, epop = 0, ebusy = 0, erv = 0;
        int wbeat = -1, rbeat = -1, d, bl;
        logic [15:0] edq = 0, erd = 0;
        logic [1:0]  edm = 0, edqs = 0;
        bl = b8_cur ? 8 : 4;
        if (rst_cur) begin
            foreach (txq[i]) if (txq[i].cut > cyc) txq[i].cut = cyc;
            free_c = cyc + 1;
        end else if (cyc >= free_c) begin
            if (rd_want) begin
                er = 1;
                txq.push_back('{rd: 1'b1, t: cyc, bl: bl, cut: 1 << 30});
                free_c = cyc + RL + bl + 1;
                last_ack = cyc;
            end else if (wr_want) begin
                ew = 1;
                txq.push_back('{rd: 1'b0, t: cyc, bl: bl, cut: 1 << 30});
                free_c = cyc + WL + bl + 2;
                last_ack = cyc;
            end
        end
        foreach (txq[i]) begin
            if (cyc < txq[i].cut) begin
                d = cyc - txq[i].t;
                if (txq[i].rd) begin
                    if (d >= 1 && d <= RL + txq[i].bl) ebusy = 1;
                    if (d >= RL - 1 && d <= RL + txq[i].bl - 1) eri = 1;
                    if (d >= RL && d < RL + txq[i].bl) rbeat = d - RL;
                    if (d >= RL + 1 && d <= RL + txq[i].bl) erv = 1;
                end else begin
                    if (d >= 1 && d <= WL + txq[i].bl + 1) ebusy = 1;
                    if (d >= WL - 1 && d <= WL + txq[i].bl) ets = 1;
                    if (d >= WL && d < WL + txq[i].bl) wbeat = d - WL;
                end
            end
        end
        while (txq.size() > 0 && (txq[0].cut <= cyc - 2 || txq[0].t + 40 < cyc))
            void'(txq.pop_front());

        reset   = rst_cur;
        wr_req  = wr_want;
        rd_req  = rd_want;
        bl8     = b8_cur;
        wr_data = (directed && wbeat >= 0) ? 16'(16'h1111 * (wbeat + 1)) : 16'($urandom);
        wr_mask = 2'($urandom);
        dq_in   = (directed && rbeat >= 0) ? 16'(16'hA000 + rbeat) : 16'($urandom);
        dq_hist[cyc] = dq_in;

        if (wbeat >= 0) begin
            epop = 1;
            edq  = wr_data;
            edm  = wr_mask;
            edqs = (wbeat % 2 == 0) ? 2'b11 : 2'b00;
        end
        if (erv) erd = dq_hist[cyc - 1];
        #1;
        o = {wr_ack, rd_ack, ts_o, ri_o, wr_pop, busy, rd_valid, dqs_o, dqsbar_o,
             dm_o, dq_o, (erv || prev_rst) ? rd_data : 16'h0000};
        e = {ew, er, ets, eri, epop, ebusy, erv, edqs, ~edqs, edm, edq, erd};
        if (rst_cur) begin
            o[42:0] = '0;
            e[42:0] = '0;
        end
        if (er) rd_want = 0;
        if (ew && !hold_wr) wr_want = 0;
        prev_rst = rst_cur;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_cur = 1; rd_want = 1; wr_want = 1; b8_cur = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL reset cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
        rst_cur = 0;
        for (int k = 0; k < 25; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL reset_release cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_write();
        directed = 1; b8_cur = 0; wr_want = 1;
        for (int k = 0; k < 12; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL write_bl4 cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
        directed = 0;
    endtask

    task automatic test_read();
        directed = 1; b8_cur = 1; rd_want = 1;
        for (int k = 0; k < 16; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL read_bl8 cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
        directed = 0;
    endtask

    task automatic test_collision();
        b8_cur = 1'($urandom); rd_want = 1; wr_want = 1;
        for (int k = 0; k < 32; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL collision cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        b8_cur = 1'($urandom); wr_want = 1;
        for (int k = 0; k < WL + 2; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL midreset_pre cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
        rst_cur = 1;
        run_cycle(obs, exp_v);
        compared++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL midreset_assert cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
        end
        rst_cur = 0; rd_want = 1;
        for (int k = 0; k < 18; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL midreset_after cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        hold_wr = 1; wr_want = 1;
        for (int k = 0; k < 45; k++) begin
            b8_cur = 1'($urandom);
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL back_to_back cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
            compared++;
            if (obs[42] && obs[41]) begin
                failed++;
                $display("FAIL ts_ri_overlap cyc=%0d got=%b%b expected=not both", cyc, obs[42], obs[41]);
            end
        end
        hold_wr = 0; wr_want = 0;
        for (int k = 0; k < 16; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL back_to_back_drain cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if (!wr_want && ($urandom % 4 == 0)) wr_want = 1;
            if (!rd_want && ($urandom % 5 == 0)) rd_want = 1;
            b8_cur  = 1'($urandom);
            rst_cur = ($urandom % 150 == 0);
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL random cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
            compared++;
            if (obs[42] && obs[41]) begin
                failed++;
                $display("FAIL random_ts_ri cyc=%0d got=%b%b expected=not both", cyc, obs[42], obs[41]);
            end
        end
        wr_want = 0; rd_want = 0; rst_cur = 0;
        for (int k = 0; k < 25; k++) begin
            run_cycle(obs, exp_v);
            compared++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL random_drain cyc=%0d got=%h expected=%h", cyc, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1; wr_req = 0; rd_req = 0; bl8 = 0;
        wr_data = 0; wr_mask = 0; dq_in = 0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_collision();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
